keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_scanner_if.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  localparam int unsigned DEBOUNCE_TICKS_DEFAULT = 20;

  // Active-low column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = COL_0;
      2'd1:    col_drive = COL_1;
      2'd2:    col_drive = COL_2;
      default: col_drive = COL_3;
    endcase
  endfunction

  // Index of the lowest-numbered row pulled low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    casez (rows)
      4'b???0: lowest_low_row = 2'd0;
      4'b??01: lowest_low_row = 2'd1;
      4'b?011: lowest_low_row = 2'd2;
      4'b0111: lowest_low_row = 2'd3;
      default: lowest_low_row = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scan tick, row/column lines and key report signals.
interface keypad_scanner_if;
  logic       clk_enable;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output clk_enable, rows,
    input  cols, key_code, key_valid, key_held
  );

  modport slave (
    input  clk_enable, rows,
    output cols, key_code, key_valid, key_held
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones (idle pulled-up lines).
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debouncing.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kp
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [3:0]    rows_s;
  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          row_low;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.rows),
    .q_o (rows_s)
  );

  assign row_low = ~rows_s[row_q];

  // Scan/debounce state register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic; everything advances only on a scan tick.
  // The column index doubles as the latched column: it is simply not
  // advanced outside SCAN, which also freezes the column drive.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (kp.clk_enable) begin
      case (state_q)
        ST_SCAN: begin
          if (rows_s == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = lowest_low_row(rows_s);
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_low) begin
            state_d = ST_SCAN;
          end else if (cnt_q >= CNT_LAST) begin
            code_d  = {row_q, col_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD: begin
          if (!row_low) begin
            cnt_d   = '0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (row_low) begin
            cnt_d = '0;
          end else if (cnt_q >= CNT_LAST) begin
            held_d  = 1'b0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_SCAN;
          col_d   = '0;
          cnt_d   = '0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  assign kp.cols      = col_drive(col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner against a tick-level reference model.
module tb_keypad_scanner;

  localparam int D = 20;

  logic clk;
  logic rst;

  keypad_scanner_if kp_bus ();

  keypad_scanner #(.DEBOUNCE_TICKS(D)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Reference model: column pointer plus run lengths of qualifying ticks.
  int       m_col;
  bit       m_cand;
  bit       m_held;
  bit       m_rel;
  int       m_row;
  int       m_kcol;
  int       m_run;
  bit [3:0] m_code;
  int       m_accepts;

  // Every clock during which key_valid is high counts once.
  always @(negedge clk) if (kp_bus.key_valid) pulse_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_cand = 0; m_held = 0; m_rel = 0;
    m_row = 0; m_kcol = 0; m_run = 0; m_code = '0;
  endtask

  function automatic int first_low(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 0;
  endfunction

  task automatic model_tick(input logic [3:0] r, output bit acc);
    acc = 0;
    if (!m_cand && !m_held) begin
      if (r == 4'hF) m_col = (m_col + 1) % 4;
      else begin
        m_cand = 1; m_row = first_low(r); m_kcol = m_col; m_run = 0;
      end
    end else if (m_cand) begin
      if (!r[m_row]) begin
        m_run++;
        if (m_run == D) begin
          m_code = 4'(m_row * 4 + m_kcol);
          m_held = 1; m_cand = 0; m_rel = 0; acc = 1; m_accepts++;
        end
      end else m_cand = 0;
    end else if (!m_rel) begin
      if (r[m_row]) begin m_rel = 1; m_run = 0; end
    end else begin
      if (r[m_row]) begin
        m_run++;
        if (m_run == D) begin
          m_held = 0; m_rel = 0; m_col = (m_kcol + 1) % 4;
        end
      end else m_run = 0;
    end
  endtask

  // Apply rows, let them cross the synchronizer, then issue one tick and check.
  task automatic step(input logic [3:0] r);
    bit acc;
    logic [3:0] exp_cols;
    @(posedge clk); #1;
    kp_bus.rows = r;
    kp_bus.clk_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    kp_bus.clk_enable = 1'b1;
    @(posedge clk); #1;
    kp_bus.clk_enable = 1'b0;
    model_tick(r, acc);
    exp_cols = 4'b1111 ^ (4'd1 << m_col);
    check_eq("cols", kp_bus.cols, exp_cols);
    check_eq("key_held", kp_bus.key_held, m_held);
    check_eq("key_code", kp_bus.key_code, m_code);
    check_eq("key_valid", kp_bus.key_valid, acc);
  endtask

  task automatic goto_col(input int c);
    for (int i = 0; i < 8 && m_col != c; i++) step(4'hF);
    check_eq("goto_col", m_col, c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cols"}, kp_bus.cols, 4'b1110);
    check_eq({tag, "_code"}, kp_bus.key_code, 4'h0);
    check_eq({tag, "_valid"}, kp_bus.key_valid, 1'b0);
    check_eq({tag, "_held"}, kp_bus.key_held, 1'b0);
  endtask

  initial begin
    int p0;
    int n;
    logic [3:0] r;
    int len;

    m_accepts = 0;
    model_reset();
    rst = 1'b1;
    kp_bus.rows = 4'hF;
    kp_bus.clk_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Idle scan: column rotates, no key reports.
    for (int i = 0; i < 8; i++) step(4'hF);

    // Row 2 pressed on column 2 long enough to accept.
    goto_col(2);
    p0 = pulse_cnt;
    for (int i = 0; i < 25; i++) step(4'b1011);
    check_eq("r2c2_code", kp_bus.key_code, 4'b1010);
    check_eq("r2c2_held", kp_bus.key_held, 1'b1);
    check_eq("r2c2_pulses", pulse_cnt - p0, 1);
    for (int i = 0; i < D + 2; i++) step(4'hF);

    // Short press on row 1 is rejected.
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) step(4'b1101);
    step(4'hF);
    check_eq("short_pulses", pulse_cnt - p0, 0);
    check_eq("short_held", kp_bus.key_held, 1'b0);

    // Accepted key with three release bounces.
    goto_col(3);
    p0 = pulse_cnt;
    for (int i = 0; i < 22; i++) step(4'b1110);
    step(4'hF); step(4'b1110);
    step(4'hF); step(4'hF); step(4'hF); step(4'b1110);
    step(4'hF); step(4'hF); step(4'b1110);
    n = 0;
    for (int i = 0; i < 30 && kp_bus.key_held; i++) begin
      step(4'hF);
      n++;
    end
    check_eq("release_len", n, D);
    check_eq("bounce_pulses", pulse_cnt - p0, 1);

    // Rows 0 and 3 together on column 1: lowest row wins.
    goto_col(1);
    for (int i = 0; i < 22; i++) step(4'b0110);
    check_eq("multi_code", kp_bus.key_code, 4'b0001);
    for (int i = 0; i < D + 2; i++) step(4'hF);

    // Reset in the middle of debouncing.
    goto_col(2);
    p0 = pulse_cnt;
    for (int i = 0; i < 11; i++) step(4'b0111);
    @(posedge clk); #3;
    rst = 1'b1;
    #1 check_reset_outputs("midrst");
    model_reset();
    kp_bus.rows = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("midrst_pulses", pulse_cnt - p0, 0);
    step(4'hF);
    step(4'hF);

    // Random row activity with varied hold times.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 1) == 0) r = 4'hF;
      else r = 4'($urandom_range(0, 14));
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) step(r);
    end
    for (int i = 0; i < D + 2; i++) step(4'hF);

    @(posedge clk); #1;
    check_eq("total_pulses", pulse_cnt, m_accepts);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
